// File: rtl/grid_round_controller.sv
// Round controller for the stabilizer PE mesh: accepts a syndrome, loads it into the
// mesh, pulses start/stop offer, waits for the mesh to settle, snapshots every PE's
// match value and hands the snapshot downstream. All outputs are decoded from registers.
module grid_round_controller #(
  parameter int unsigned ROWS              = 2,
  parameter int unsigned COLS              = 3,
  parameter int unsigned MATCH_VALUE_WIDTH = 8,
  parameter int unsigned OFFER_CYCLES      = 16,
  parameter int unsigned SETTLE_CYCLES     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ROWS*COLS-1:0]                  syndrome_in,
  input  logic                                  syndrome_valid,
  output logic                                  syndrome_ready,
  output logic [ROWS*COLS-1:0]                  measurement_value_out,
  output logic [ROWS*COLS-1:0]                  measurement_valid_out,
  output logic                                  start_offer,
  output logic                                  stop_offer,
  input  logic [ROWS*COLS*MATCH_VALUE_WIDTH-1:0] match_value_in,
  output logic [ROWS*COLS*MATCH_VALUE_WIDTH-1:0] result_out,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  busy,
  output logic [15:0]                           decode_cycles
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned ResW   = N * MATCH_VALUE_WIDTH;
  localparam int unsigned MaxCnt = (OFFER_CYCLES > SETTLE_CYCLES) ? OFFER_CYCLES : SETTLE_CYCLES;
  // Down-counter only ever holds (cycles - 1).
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] OfferLoad  = CntW'(OFFER_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StStart   = 3'd2;
  localparam logic [2:0] StOffer   = 3'd3;
  localparam logic [2:0] StStop    = 3'd4;
  localparam logic [2:0] StSettle  = 3'd5;
  localparam logic [2:0] StCapture = 3'd6;
  localparam logic [2:0] StOutput  = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [N-1:0]    synd_q, synd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     cyc_q, cyc_d;
  logic [ResW-1:0] res_q, res_d;
  logic [15:0]     dec_q, dec_d;

  // Next-state logic: FSM sequencing, phase counter, round-length counter, snapshot.
  always_comb begin
    state_d = state_q;
    synd_d  = synd_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    res_d   = res_q;
    dec_d   = dec_q;

    // Round-length counter runs in every non-idle cycle and saturates.
    if (state_q != StIdle) begin
      cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (syndrome_valid) begin
          synd_d = syndrome_in;
          // Starts at 1 so the entry cycle itself is counted.
          cyc_d  = 16'd1;
          if (syndrome_in == '0) begin
            // Nothing to decode: skip the mesh and report an all-zero result.
            res_d   = '0;
            state_d = StOutput;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad:  state_d = StStart;
      StStart: begin
        cnt_d   = OfferLoad;
        state_d = StOffer;
      end
      StOffer: begin
        if (cnt_q == '0) state_d = StStop;
        else             cnt_d   = cnt_q - CntOne;
      end
      StStop: begin
        cnt_d   = SettleLoad;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCapture;
        else             cnt_d   = cnt_q - CntOne;
      end
      StCapture: begin
        res_d   = match_value_in;
        state_d = StOutput;
      end
      StOutput: begin
        if (result_ready) begin
          dec_d   = cyc_q;
          cyc_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      synd_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      synd_q  <= synd_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      dec_q   <= dec_d;
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    syndrome_ready        = (state_q == StIdle);
    busy                  = (state_q != StIdle);
    measurement_value_out = synd_q;
    measurement_valid_out = {N{state_q == StLoad}};
    start_offer           = (state_q == StStart);
    stop_offer            = (state_q == StStop);
    result_out            = res_q;
    result_valid          = (state_q == StOutput);
    decode_cycles         = dec_q;
  end

endmodule

// File: tb/tb_grid_round_controller.sv
// Directed bench for grid_round_controller with default parameters (2x3 mesh).
module tb_grid_round_controller;

  localparam int N  = 6;
  localparam int RW = 48;

  logic          clk;
  logic          reset;
  logic [N-1:0]  syndrome_in;
  logic          syndrome_valid;
  logic          syndrome_ready;
  logic [N-1:0]  measurement_value_out;
  logic [N-1:0]  measurement_valid_out;
  logic          start_offer;
  logic          stop_offer;
  logic [RW-1:0] match_value_in;
  logic [RW-1:0] result_out;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic [15:0]   decode_cycles;

  int total = 0;
  int bad   = 0;

  grid_round_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .syndrome_in           (syndrome_in),
    .syndrome_valid        (syndrome_valid),
    .syndrome_ready        (syndrome_ready),
    .measurement_value_out (measurement_value_out),
    .measurement_valid_out (measurement_valid_out),
    .start_offer           (start_offer),
    .stop_offer            (stop_offer),
    .match_value_in        (match_value_in),
    .result_out            (result_out),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .busy                  (busy),
    .decode_cycles         (decode_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  syn;
    logic [RW-1:0] mv;
    int            delay;   // cycles result_ready stays low after result_valid
    bit            hold;    // drive syndrome_valid while busy
    int            lat;     // cycle of first result_valid (t0 = accept edge)
    int            dec;     // expected decode_cycles
    logic [RW-1:0] res;
    int            start;   // cycle of start_offer pulse, 0 = never
    int            stop;    // cycle of stop_offer pulse, 0 = never
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE, ends at a negedge in IDLE after the result handshake.
  task automatic run_round(input vec_t v);
    int k;
    int lat;
    int nstart;
    int nstop;
    int fstart;
    int fstop;
    lat = 0; nstart = 0; nstop = 0; fstart = 0; fstop = 0;
    chk("idle_ready", 64'(syndrome_ready), 64'd1);
    syndrome_in    = v.syn;
    syndrome_valid = 1'b1;
    match_value_in = v.mv;
    result_ready   = 1'b0;
    @(negedge clk);
    syndrome_valid = v.hold;
    syndrome_in    = ~v.syn;
    k = 1;
    while (k <= 100) begin
      if (k == 1) begin
        chk("meas_valid_t1", 64'(measurement_valid_out), (v.syn != 0) ? 64'h3F : 64'h0);
        if (v.syn != 0) chk("meas_value_t1", 64'(measurement_value_out), 64'(v.syn));
      end
      if (k == 2) chk("meas_valid_t2", 64'(measurement_valid_out), 64'h0);
      if (start_offer) begin nstart++; if (fstart == 0) fstart = k; end
      if (stop_offer)  begin nstop++;  if (fstop == 0)  fstop  = k; end
      if (result_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(lat), 64'(v.lat));
    if (lat == 0) begin
      syndrome_valid = 1'b0;
      return;
    end
    chk("start_count", 64'(nstart), (v.start != 0) ? 64'd1 : 64'd0);
    chk("start_cycle", 64'(fstart), 64'(v.start));
    chk("stop_count", 64'(nstop), (v.stop != 0) ? 64'd1 : 64'd0);
    chk("stop_cycle", 64'(fstop), 64'(v.stop));
    chk("result", 64'(result_out), 64'(v.res));
    for (int d = 0; d < v.delay; d++) begin
      match_value_in = ~match_value_in;
      @(negedge clk);
      chk("bp_valid", 64'(result_valid), 64'd1);
      chk("bp_result", 64'(result_out), 64'(v.res));
      chk("bp_synd_ready", 64'(syndrome_ready), 64'd0);
    end
    result_ready   = 1'b1;
    syndrome_valid = 1'b0;
    @(negedge clk);
    result_ready = 1'b0;
    chk("decode_cycles", 64'(decode_cycles), 64'(v.dec));
    chk("post_valid", 64'(result_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_synd_ready", 64'(syndrome_ready), 64'd1);
  endtask

  initial begin
    logic [7:0]    b;
    logic [RW-1:0] snap_exp;
    int            k;
    int            lat;
    int            rv_seen;

    vecs[0] = '{6'b000101, 48'h0123456789AB, 0,  1'b0, 25, 25, 48'h0123456789AB, 2, 19};
    vecs[1] = '{6'b000000, 48'hFFFFFFFFFFFF, 0,  1'b0, 1,  1,  48'h0,            0, 0};
    vecs[2] = '{6'b111111, 48'hA5A55A5AC3C3, 10, 1'b1, 25, 35, 48'hA5A55A5AC3C3, 2, 19};
    vecs[3] = '{6'b100000, 48'h00FF00FF1234, 3,  1'b0, 25, 28, 48'h00FF00FF1234, 2, 19};
    vecs[4] = '{6'b000000, 48'h123456789ABC, 2,  1'b1, 1,  3,  48'h0,            0, 0};

    // Reset with random inputs.
    reset          = 1'b0;
    syndrome_in    = 6'($urandom);
    syndrome_valid = 1'b1;
    match_value_in = {16'($urandom), 32'($urandom)};
    result_ready   = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_synd_ready", 64'(syndrome_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_meas_value", 64'(measurement_value_out), 64'd0);
    chk("rst_meas_valid", 64'(measurement_valid_out), 64'd0);
    chk("rst_start", 64'(start_offer), 64'd0);
    chk("rst_stop", 64'(stop_offer), 64'd0);
    chk("rst_result", 64'(result_out), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_decode", 64'(decode_cycles), 64'd0);
    reset          = 1'b1;
    syndrome_valid = 1'b0;
    result_ready   = 1'b0;
    @(negedge clk);
    chk("rel_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++) run_round(vecs[i]);

    // Snapshot isolation: match_value_in changes every cycle.
    syndrome_in    = 6'b010010;
    syndrome_valid = 1'b1;
    @(negedge clk);
    syndrome_valid = 1'b0;
    k = 1; lat = 0;
    while (k <= 100) begin
      if (result_valid) begin
        lat = k;
        break;
      end
      b = 8'(k) + 8'h30;
      match_value_in = {6{b}};
      @(negedge clk);
      k++;
    end
    b = 8'd24 + 8'h30;
    snap_exp = {6{b}};
    chk("snap_latency", 64'(lat), 64'd25);
    chk("snap_result", 64'(result_out), 64'(snap_exp));
    for (int d = 0; d < 2; d++) begin
      match_value_in = {6{8'(d)}};
      @(negedge clk);
      chk("snap_hold", 64'(result_out), 64'(snap_exp));
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("snap_decode", 64'(decode_cycles), 64'd27);

    // Reset asserted during the stop_offer pulse.
    syndrome_in    = 6'b001100;
    syndrome_valid = 1'b1;
    @(negedge clk);
    syndrome_valid = 1'b0;
    for (int c = 1; c < 19; c++) @(negedge clk);
    chk("mid_stop_before", 64'(stop_offer), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_stop_after", 64'(stop_offer), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_synd_ready", 64'(syndrome_ready), 64'd1);
    chk("mid_decode", 64'(decode_cycles), 64'd0);
    @(negedge clk);
    reset   = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (result_valid || busy) rv_seen++;
    end
    chk("mid_no_result", 64'(rv_seen), 64'd0);
    run_round(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
